// File: rtl/ama_riscv_fetch_buffer.sv
// Fetch front end: owns the fetch PC, issues IMEM reads and queues PC-tagged words for ID.
// Optional FB_BYPASS_EN lets an arriving word skip an empty queue straight to ID.
module ama_riscv_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IMEM_AW  = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_en,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [31:0]                id_inst,
  output logic [31:0]                id_pc,
  output logic [$clog2(DEPTH+1)-1:0] fb_count
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [31:0]   issue_pc;
  logic [CW:0]   credit_used;
  logic          word_live;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [31:0]   head_inst;
  logic [31:0]   head_pc;

  assign issue_pc    = redirect_en ? {redirect_pc[31:2], 2'b00} : fetch_pc;
  assign imem_addr   = issue_pc[IMEM_AW+1:2];
  // The in-flight word already owns a slot; a same-cycle pop gives no credit back.
  assign credit_used = {1'b0, count} + (CW + 1)'(inflight);
  assign imem_req    = !rst && (redirect_en || (credit_used < DEPTH_W));
  // A redirect kills whatever word lands in the same cycle.
  assign word_live   = inflight && !redirect_en;
  assign fifo_empty  = (count == '0);
  assign fb_count    = count;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    head_inst = inst_mem[rd_ptr];
    head_pc   = pc_mem[rd_ptr];
    id_valid  = !fifo_empty;
    push      = word_live;
    pop       = !fifo_empty && id_ready && !redirect_en;
`ifdef FB_BYPASS_EN
    if (fifo_empty && word_live) begin
      head_inst = imem_rdata;
      head_pc   = inflight_pc;
      id_valid  = 1'b1;
      push      = !id_ready;
    end
`endif
    id_inst = id_valid ? head_inst : NOP;
    id_pc   = id_valid ? head_pc : 32'h0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc    <= issue_pc + 32'd4;
        inflight_pc <= issue_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so its contents never matter when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule
